irda_sir_receiver: RTL
======================

# irda_sir_receiver

Serial-to-byte receiver for SIR mode. It consumes the NRZ bit stream produced by the SIR pulse decoder (`sir_dec_o`, one bit held per 16 oversample ticks, idle high) and extracts asynchronous frames: start bit, `DATA_BITS` data bits LSB-first, and one stop bit. Received bytes and their frame-error flags go into a small FIFO that the Wishbone register layer drains through a valid/ready handshake.

## Interface
- `DATA_BITS`, 8: data bits per frame.
- `FIFO_DEPTH`, 4: receive FIFO entries; must be a power of two, at least 2.
- `clk` in 1: system clock.
- `wb_rst_i` in 1: reset, asynchronous, active-high.
- `fast_enable` in 1: 16x-baud tick enable, the same strobe that drives the decoder.
- `fast_mode` in 1: MIR/FIR mode selected; the SIR receiver is held idle.
- `tx_select` in 1: transmitter owns the link; the receiver is held idle.
- `sir_dec_i` in 1: decoded NRZ bit from the SIR decoder; idle = 1.
- `data_o` out `DATA_BITS`: data of the FIFO head entry.
- `frame_err_o` out 1: stop-bit error flag of the FIFO head entry.
- `valid_o` out 1: FIFO not empty.
- `ready_i` in 1: consumer accepts the head entry; a pop occurs when `valid_o && ready_i`.
- `overrun_o` out 1: sticky flag, set when a frame is dropped because the FIFO is full.
- `ovr_clr_i` in 1: single-cycle clear of `overrun_o`.
- `rx_busy_o` out 1: high whenever the FSM is not in IDLE.

## Operation
- **Tick:** `tick = fast_enable && !tx_select && !fast_mode`. The FSM and its counters advance only on tick cycles.
- **Abort:** if `tx_select` or `fast_mode` is high in any cycle, the FSM goes to IDLE synchronously. `cnt`, `bitidx` and the shift register clear, and the partial frame is discarded. FIFO contents and `overrun_o` are kept.
- **Counters:** `cnt` is 4 bits and `bitidx` is ceil(log2(`DATA_BITS`+1)) bits.
- **FSM states:**
  - IDLE: on a tick with `sir_dec_i==0`, go to START and set `cnt<=0`.
  - START: on each tick, if `cnt==7`, sample mid-bit:
    - sample 0: go to DATA, `cnt<=0`, `bitidx<=0`;
    - sample 1: false start, go to IDLE.
    - Otherwise `cnt<=cnt+1`.
  - DATA: on each tick, if `cnt==15`, shift `sir_dec_i` into the MSB of the shift register (right shift, so the first data bit ends up at LSB). Then `cnt<=0` and `bitidx<=bitidx+1`. After the `DATA_BITS`-th sample, go to STOP. Otherwise `cnt<=cnt+1`.
  - STOP: on the tick with `cnt==15`, sample the stop bit and push `{ferr = !sir_dec_i, shift_reg}`:
    - stop bit 1: go to IDLE;
    - stop bit 0: go to WAIT_HIGH.
  - WAIT_HIGH: stay until a tick with `sir_dec_i==1`, then go to IDLE. This prevents a break or stuck-low line from retriggering start detection.
- **Frame errors:** a frame with a bad stop bit is still pushed, with `frame_err_o` set for that entry.
- **FIFO push:**
  - Push while not full: write the entry at the write pointer.
  - Push while full with no pop in the same cycle: drop the entry and set `overrun_o`.
  - Push and pop in the same cycle while full: the push is accepted and there is no overrun.
- **Overrun clear:** when `ovr_clr_i` and a new overrun occur in the same cycle, the set wins.
- **Pointers:** read and write pointers wrap modulo `FIFO_DEPTH`. `count` is ceil(log2(`FIFO_DEPTH`+1)) bits. A pop while empty is ignored.

## Timing
- **Reset values:** FSM=IDLE, `cnt=0`, `bitidx=0`, shift register 0, FIFO pointers and count 0, storage 0. Outputs: `data_o=0`, `frame_err_o=0`, `valid_o=0`, `overrun_o=0`, `rx_busy_o=0`.
- **Start-to-push latency:** the push happens on the clock edge of the stop-sample tick. That tick is the 8 + 16×(`DATA_BITS`+1) = 152nd tick after the start-detect tick, with default parameters.
- **Output timing:**
  - `valid_o` is decoded combinationally from the registered count, so it rises the cycle after the push edge.
  - `data_o` and `frame_err_o` are valid whenever `valid_o` is high.
  - After a pop edge they show the next entry in the following cycle.
- **`rx_busy_o`:** registered; high from the cycle after start detection until the cycle after IDLE is re-entered.
- **Reset mid-frame:** asynchronously returns everything to reset values; the partial frame is lost.

## Structure
- Constants go in `irda_defines.v`:
  - FSM state encodings (IDLE, START, DATA, STOP, WAIT_HIGH; 3-bit);
  - `IRDA_SIR_OVERSAMPLE` = 16;
  - mid-sample index 7.
- One sub-module, `irda_rx_fifo`:
  - parameterised width (`DATA_BITS`+1) and depth;
  - push/pop, full/empty, overrun detection;
  - head output combinational from the storage array.
- The FSM, counters and shift register stay in `irda_sir_receiver`.

## Test plan
- **Single byte:** `fast_enable` every cycle; drive `sir_dec_i` NRZ at 16 cycles/bit for start, 0xA5, stop=1. Expect `data_o=0xA5`, `frame_err_o=0`, `valid_o` rising 153 cycles after the start-bit edge; pulse `ready_i` and expect `valid_o=0`.
- **Glitch start:** `sir_dec_i` low for 4 ticks, then high. Expect return to IDLE, no push, `rx_busy_o` low again by tick 9.
- **Framing error:** frame 0x3C with stop bit 0, line low 40 more ticks, then high, then a frame 0x81. Expect entries {0x3C, ferr=1} then {0x81, ferr=0}, and no spurious frame while the line stays low.
- **Overrun:** `ready_i=0`; send 5 frames (0x01..0x05) with `FIFO_DEPTH`=4. Expect `overrun_o=1`, FIFO holding 0x01..0x04; `ovr_clr_i` clears the flag. Then a full-FIFO push with a simultaneous pop must not set overrun.
- **Abort:** assert `tx_select` (then, separately, `fast_mode`) mid-DATA. Expect IDLE, no push, `rx_busy_o=0`, existing FIFO entries intact.
- **Async reset:** assert `wb_rst_i` during STOP with 2 entries queued. Expect all outputs at reset values immediately.

Source files
------------

// File: rtl/irda_sir_receiver_pkg.sv
// Shared constants and types for the SIR receive path.
//   rx_state_e      : receive FSM state encoding (3 bits)
//   IRDA_SIR_OVERSAMPLE : oversample ticks per NRZ bit
//   SIR_MID_IDX     : tick index used to re-check the start bit mid-bit
//   SIR_LAST_IDX    : last tick index of a bit period (data/stop sample point)
package irda_sir_receiver_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_STOP      = 3'd3,
    ST_WAIT_HIGH = 3'd4
  } rx_state_e;

  localparam int         IRDA_SIR_OVERSAMPLE = 16;
  localparam logic [3:0] SIR_MID_IDX         = 4'd7;
  localparam logic [3:0] SIR_LAST_IDX        = 4'(IRDA_SIR_OVERSAMPLE - 1);

endpackage

// File: rtl/irda_sir_receiver_fifo.sv
// Small receive FIFO between the SIR frame extractor and the register layer.
// Ports:
//   clk, wb_rst_i : clock, asynchronous active-high reset
//   push_i/din_i  : write request and entry {ferr, data}
//   pop_i         : consumer accepts the head entry (ignored while empty)
//   dout_o        : head entry, combinational from storage
//   valid_o       : FIFO not empty
//   overrun_o     : sticky, set when a push is dropped because the FIFO is full
//   ovr_clr_i     : clears overrun_o; a simultaneous new overrun wins
module irda_rx_fifo #(
  parameter int WIDTH = 9,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             wb_rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] din_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] dout_o,
  output logic             valid_o,
  output logic             overrun_o,
  input  logic             ovr_clr_i
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             overrun_q, overrun_d;
  logic             full, empty, pop_ok, push_ok, ovr_set;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == {CNT_W{1'b0}});
  assign pop_ok  = pop_i && !empty;
  // A push into a full FIFO still fits when the head leaves in the same cycle.
  assign push_ok = push_i && (!full || pop_ok);
  assign ovr_set = push_i && full && !pop_ok;

  assign dout_o    = mem_q[rd_ptr_q];
  assign valid_o   = !empty;
  assign overrun_o = overrun_q;

  // Next-state for pointers, occupancy and the sticky overrun flag.
  always_comb begin
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    else         wr_ptr_d = wr_ptr_q;
    if (pop_ok)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    else         rd_ptr_d = rd_ptr_q;
    case ({push_ok, pop_ok})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
    if (ovr_set)        overrun_d = 1'b1;
    else if (ovr_clr_i) overrun_d = 1'b0;
    else                overrun_d = overrun_q;
  end

  // Control registers.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      wr_ptr_q  <= {PTR_W{1'b0}};
      rd_ptr_q  <= {PTR_W{1'b0}};
      count_q   <= {CNT_W{1'b0}};
      overrun_q <= 1'b0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // Entry storage; cleared on reset so the head reads zero when empty.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= {WIDTH{1'b0}};
    end else if (push_ok) begin
      mem_q[wr_ptr_q] <= din_i;
    end
  end

endmodule

// File: rtl/irda_sir_receiver.sv
// SIR receiver: extracts start / DATA_BITS (LSB first) / stop frames from the
// decoded NRZ stream (16 ticks per bit) and queues {frame_err, data} entries.
// Ports:
//   clk, wb_rst_i          : clock, asynchronous active-high reset
//   fast_enable            : 16x-baud tick strobe
//   fast_mode, tx_select   : either one holds the receiver idle (aborts a frame)
//   sir_dec_i              : decoded NRZ bit, idle high
//   data_o, frame_err_o    : FIFO head entry
//   valid_o / ready_i      : FIFO head handshake
//   overrun_o / ovr_clr_i  : sticky dropped-frame flag and its clear
//   rx_busy_o              : registered, FSM outside IDLE
module irda_sir_receiver
  import irda_sir_receiver_pkg::*;
#(
  parameter int DATA_BITS  = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                 clk,
  input  logic                 wb_rst_i,
  input  logic                 fast_enable,
  input  logic                 fast_mode,
  input  logic                 tx_select,
  input  logic                 sir_dec_i,
  output logic [DATA_BITS-1:0] data_o,
  output logic                 frame_err_o,
  output logic                 valid_o,
  input  logic                 ready_i,
  output logic                 overrun_o,
  input  logic                 ovr_clr_i,
  output logic                 rx_busy_o
);

  localparam int BIDX_W = $clog2(DATA_BITS + 1);

  rx_state_e            state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic [BIDX_W-1:0]    bitidx_q, bitidx_d;
  logic [DATA_BITS-1:0] shift_q, shift_d;
  logic                 rx_busy_q;
  logic                 tick, abort, rx_push;
  logic [DATA_BITS:0]   push_data;
  logic [DATA_BITS:0]   head;

  assign abort     = tx_select || fast_mode;
  assign tick      = fast_enable && !abort;
  assign push_data = {!sir_dec_i, shift_q};

  // Frame FSM next-state, counters, shift register and push strobe.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bitidx_d = bitidx_q;
    shift_d  = shift_q;
    rx_push  = 1'b0;
    if (abort) begin
      state_d  = ST_IDLE;
      cnt_d    = 4'd0;
      bitidx_d = {BIDX_W{1'b0}};
      shift_d  = {DATA_BITS{1'b0}};
    end else if (tick) begin
      case (state_q)
        ST_IDLE: begin
          if (!sir_dec_i) begin
            state_d = ST_START;
            cnt_d   = 4'd0;
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_START: begin
          if (cnt_q == SIR_MID_IDX) begin
            // Mid-bit re-check rejects glitches shorter than half a bit.
            if (!sir_dec_i) begin
              state_d  = ST_DATA;
              cnt_d    = 4'd0;
              bitidx_d = {BIDX_W{1'b0}};
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_DATA: begin
          if (cnt_q == SIR_LAST_IDX) begin
            // Right shift: the first data bit lands in the LSB.
            shift_d  = {sir_dec_i, shift_q[DATA_BITS-1:1]};
            cnt_d    = 4'd0;
            bitidx_d = bitidx_q + BIDX_W'(1);
            if (bitidx_q == BIDX_W'(DATA_BITS - 1)) state_d = ST_STOP;
            else                                    state_d = ST_DATA;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_STOP: begin
          if (cnt_q == SIR_LAST_IDX) begin
            rx_push = 1'b1;
            cnt_d   = 4'd0;
            // A low stop bit may be a break; wait for the line to recover.
            if (sir_dec_i) state_d = ST_IDLE;
            else           state_d = ST_WAIT_HIGH;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end
        ST_WAIT_HIGH: begin
          if (sir_dec_i) state_d = ST_IDLE;
          else           state_d = ST_WAIT_HIGH;
        end
        default: begin
          state_d  = ST_IDLE;
          cnt_d    = 4'd0;
          bitidx_d = {BIDX_W{1'b0}};
          shift_d  = {DATA_BITS{1'b0}};
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // FSM, counter and shift register state; busy lags the FSM by one cycle.
  always_ff @(posedge clk or posedge wb_rst_i) begin
    if (wb_rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= 4'd0;
      bitidx_q  <= {BIDX_W{1'b0}};
      shift_q   <= {DATA_BITS{1'b0}};
      rx_busy_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      bitidx_q  <= bitidx_d;
      shift_q   <= shift_d;
      rx_busy_q <= (state_q != ST_IDLE);
    end
  end

  irda_rx_fifo #(
    .WIDTH (DATA_BITS + 1),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .wb_rst_i  (wb_rst_i),
    .push_i    (rx_push),
    .din_i     (push_data),
    .pop_i     (ready_i),
    .dout_o    (head),
    .valid_o   (valid_o),
    .overrun_o (overrun_o),
    .ovr_clr_i (ovr_clr_i)
  );

  assign data_o      = head[DATA_BITS-1:0];
  assign frame_err_o = head[DATA_BITS];
  assign rx_busy_o   = rx_busy_q;

endmodule
